// File: rtl/unrank_pkg.sv
// Shared FSM encoding, default widths and the binomial helper for the unrank block.
package unrank_pkg;

  localparam int NUM_WIDTH_DEF = 10;
  localparam int ROWS_NUM_DEF  = 13;
  localparam int COL_WIDTH_DEF = 4;
  localparam int ROW_WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    EMIT   = 2'd2
  } state_t;

  // C(n,k), zero when k > n; only ever evaluated at elaboration time.
  function automatic int binom(input int n, input int k);
    int res;
    res = 1;
    if (k < 0 || k > n) begin
      res = 0;
    end else begin
      for (int i = 0; i < k; i++) begin
        res = res * (n - i) / (i + 1);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/unrank_ctrl_tbl.sv
// Binomial lookup: largest row r with C(r,col) <= num, plus that C(r,col).
// Purely combinational; rows saturate at ROWS_NUM-1 when num exceeds the table.
module tbl
  import unrank_pkg::*;
#(
  parameter int NUM_WIDTH   = NUM_WIDTH_DEF,
  parameter int ROWS_NUM    = ROWS_NUM_DEF,
  parameter int VALUE_WIDTH = NUM_WIDTH,
  parameter int COL_WIDTH   = COL_WIDTH_DEF,
  parameter int ROW_WIDTH   = ROW_WIDTH_DEF
) (
  input  logic [NUM_WIDTH-1:0]   num_i,
  input  logic [COL_WIDTH-1:0]   col_i,
  output logic [ROW_WIDTH-1:0]   row_o,
  output logic [VALUE_WIDTH-1:0] val_o
);

  logic [VALUE_WIDTH-1:0] tab [ROWS_NUM][ROWS_NUM];

  for (genvar r = 0; r < ROWS_NUM; r++) begin : g_row
    for (genvar c = 0; c < ROWS_NUM; c++) begin : g_col
      assign tab[r][c] = VALUE_WIDTH'(binom(r, c));
    end
  end

  // C(r,col) is non-decreasing in r, so the last row that fits wins.
  always_comb begin
    logic [VALUE_WIDTH-1:0] v;
    row_o = '0;
    val_o = '0;
    for (int r = 0; r < ROWS_NUM; r++) begin
      v = '0;
      for (int c = 0; c < ROWS_NUM; c++) begin
        if (col_i == COL_WIDTH'(c)) v = tab[r][c];
      end
      if (v <= num_i) begin
        row_o = ROW_WIDTH'(r);
        val_o = v;
      end
    end
  end

endmodule

// File: rtl/unrank_ctrl.sv
// Unranks a k-combination one element per LOOKUP/EMIT pair, largest element first.
// Elements hold on out_elem until out_ready; bad k is dropped with a one-cycle err.
module unrank_ctrl
  import unrank_pkg::*;
#(
  parameter int NUM_WIDTH   = NUM_WIDTH_DEF,
  parameter int ROWS_NUM    = ROWS_NUM_DEF,
  parameter int VALUE_WIDTH = NUM_WIDTH,
  parameter int COL_WIDTH   = COL_WIDTH_DEF,
  parameter int ROW_WIDTH   = ROW_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NUM_WIDTH-1:0] in_rank,
  input  logic [COL_WIDTH-1:0] in_k,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ROW_WIDTH-1:0] out_elem,
  output logic                 out_last,
  output logic                 err
);

  state_t                 state_q, state_d;
  logic [NUM_WIDTH-1:0]   num_q, num_d;
  logic [COL_WIDTH-1:0]   col_q, col_d;
  logic [ROW_WIDTH-1:0]   elem_q, elem_d;
  logic                   out_valid_q, out_valid_d;
  logic                   err_q, err_d;
  logic [ROW_WIDTH-1:0]   tbl_row;
  logic [VALUE_WIDTH-1:0] tbl_val;

  tbl #(
    .NUM_WIDTH  (NUM_WIDTH),
    .ROWS_NUM   (ROWS_NUM),
    .VALUE_WIDTH(VALUE_WIDTH),
    .COL_WIDTH  (COL_WIDTH),
    .ROW_WIDTH  (ROW_WIDTH)
  ) u_tbl (
    .num_i(num_q),
    .col_i(col_q),
    .row_o(tbl_row),
    .val_o(tbl_val)
  );

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    col_d   = col_q;
    elem_d  = elem_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_k != '0 && int'(in_k) < ROWS_NUM) begin
            num_d   = in_rank;
            col_d   = in_k;
            state_d = LOOKUP;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOOKUP: begin
        elem_d  = tbl_row;
        num_d   = num_q - tbl_val;
        state_d = EMIT;
      end
      EMIT: begin
        if (out_ready) begin
          if (col_q == COL_WIDTH'(1)) begin
            state_d = IDLE;
          end else begin
            col_d   = col_q - COL_WIDTH'(1);
            state_d = LOOKUP;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    out_valid_d = (state_d == EMIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      num_q       <= '0;
      col_q       <= '0;
      elem_q      <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_q       <= num_d;
      col_q       <= col_d;
      elem_q      <= elem_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_elem  = elem_q;
  assign out_last  = out_valid_q && (col_q == COL_WIDTH'(1));
  assign err       = err_q;

endmodule

// File: tb/tb_unrank_ctrl.sv
// Directed bench for unrank_ctrl with hand-computed combinations.
module tb_unrank_ctrl;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] in_rank;
  logic [3:0] in_k;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_elem;
  logic       out_last;
  logic       err;

  int n_checks = 0;
  int n_errors = 0;
  int exp_e[$];

  unrank_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_rank  (in_rank),
    .in_k     (in_k),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_elem (out_elem),
    .out_last (out_last),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Presents one request; returns 1ns after the accepting edge.
  task automatic req(input logic [9:0] rank, input logic [3:0] k);
    @(negedge clk);
    in_valid = 1'b1;
    in_rank  = rank;
    in_k     = k;
    check("in_ready_at_req", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Drains exp_e; stalls out_ready for 'stall' cycles on the first element.
  task automatic collect(input int stall);
    int got;
    int edge_n;
    int stalled;
    int n;
    got     = 0;
    edge_n  = 0;
    stalled = 0;
    n       = exp_e.size();
    while (got < n && edge_n < 60) begin
      @(negedge clk);
      if (out_valid) begin
        if (stalled < stall) begin
          out_ready = 1'b0;
          stalled++;
          check("stall_elem", out_elem, exp_e[got]);
          check("stall_last", out_last, 0);
        end else begin
          out_ready = 1'b1;
          check("elem", out_elem, exp_e[got]);
          check("last", out_last, (got == n - 1) ? 1 : 0);
          if (stall == 0) check("timing", edge_n + 1, 2 * (got + 1));
          got++;
        end
      end else begin
        check("no_ready_while_busy", in_ready, 0);
      end
      @(posedge clk);
      edge_n++;
    end
    check("elem_count", got, n);
    @(negedge clk);
    out_ready = 1'b1;
    check("in_ready_return", in_ready, 1);
    check("valid_drop", out_valid, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_rank   = '0;
    in_k      = '0;
    out_ready = 1'b1;
    #3;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_err", err, 0);
    check("rst_out_elem", out_elem, 0);
    @(negedge clk);
    rst_n = 1'b1;

    exp_e = '{3, 2};
    req(10'd5, 4'd2);
    collect(0);

    exp_e = '{2, 1, 0};
    req(10'd0, 4'd3);
    collect(0);

    exp_e = '{11, 10, 9};
    req(10'd219, 4'd3);
    collect(0);

    exp_e = '{7};
    req(10'd7, 4'd1);
    collect(0);

    // Rank beyond C(12,1) saturates to the top row.
    exp_e = '{12};
    req(10'd1000, 4'd1);
    collect(0);

    // Largest legal k: rank 0 gives 11 down to 0.
    exp_e = '{11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
    req(10'd0, 4'd12);
    collect(0);

    req(10'd5, 4'd0);
    check("err_k0", err, 1);
    check("err_k0_ready", in_ready, 1);
    check("err_k0_valid", out_valid, 0);
    @(posedge clk);
    #1;
    check("err_k0_clear", err, 0);

    req(10'd5, 4'd13);
    check("err_k13", err, 1);
    check("err_k13_ready", in_ready, 1);
    check("err_k13_valid", out_valid, 0);
    @(posedge clk);
    #1;
    check("err_k13_clear", err, 0);
    check("err_k13_valid2", out_valid, 0);

    exp_e = '{3, 2};
    req(10'd5, 4'd2);
    collect(5);

    @(negedge clk);
    out_ready = 1'b0;
    req(10'd219, 4'd3);
    @(posedge clk);
    #1;
    check("pre_rst_valid", out_valid, 1);
    check("pre_rst_elem", out_elem, 11);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_ready", in_ready, 1);
    check("mid_rst_elem", out_elem, 0);
    check("mid_rst_last", out_last, 0);
    check("mid_rst_err", err, 0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    exp_e = '{3, 2};
    req(10'd5, 4'd2);
    collect(0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
